// File: rtl/sd4_align_sched.sv
// SD4 exponent-alignment sequencer: buffers one group of partial products,
// tracks the group max exponent, then issues entries to one shared aligner.
module sd4_align_sched #(
    parameter int N  = 9,
    parameter int EW = 5,
    parameter int PW = 5
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [EW-1:0] in_exp_i,
    input  logic [PW-1:0] in_pp_i,
    output logic          align_valid_o,
    input  logic          align_ready_i,
    output logic [PW-1:0] align_pp_o,
    output logic [EW-1:0] align_exp_o,
    output logic [EW-1:0] align_exp_max_o,
    output logic [3:0]    align_shift_o,
    output logic [3:0]    align_idx_o,
    output logic          align_last_o,
    output logic          group_done_o
);

    typedef enum logic {
        LOAD,
        ISSUE
    } state_e;

    localparam logic [EW-1:0]        EXP_MIN = {1'b1, {(EW-1){1'b0}}};
    localparam logic [3:0]           LAST    = 4'(N-1);
    localparam logic signed [EW:0]   SAT     = (EW+1)'(15);

    state_e        state_q;
    logic [3:0]    wr_cnt_q;
    logic [3:0]    rd_cnt_q;
    logic [EW-1:0] exp_max_q;
    logic [PW-1:0] pp_q  [N];
    logic [EW-1:0] exp_q [N];

    logic          in_ready_q;
    logic          align_valid_q;
    logic [PW-1:0] align_pp_q;
    logic [EW-1:0] align_exp_q;
    logic [EW-1:0] align_exp_max_q;
    logic [3:0]    align_shift_q;
    logic [3:0]    align_idx_q;
    logic          align_last_q;
    logic          group_done_q;

    logic [EW-1:0] exp_max_d;
    logic [3:0]    rd_nxt;

    // Negative differences only arise from zero-magnitude entries.
    function automatic logic [3:0] sat_shift(input logic [EW-1:0] mx,
                                             input logic [EW-1:0] e);
        logic signed [EW:0] diff;
        diff = $signed({mx[EW-1], mx}) - $signed({e[EW-1], e});
        if (diff[EW] || diff > SAT) return 4'hf;
        return diff[3:0];
    endfunction

    always_comb begin
        exp_max_d = exp_max_q;
        if (state_q == LOAD && in_valid_i && (|in_pp_i[PW-2:0]) &&
            ($signed(in_exp_i) > $signed(exp_max_q)))
            exp_max_d = in_exp_i;
    end

    assign rd_nxt = rd_cnt_q + 4'd1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= LOAD;
            wr_cnt_q        <= '0;
            rd_cnt_q        <= '0;
            exp_max_q       <= EXP_MIN;
            for (int i = 0; i < N; i++) begin
                pp_q[i]  <= '0;
                exp_q[i] <= '0;
            end
            in_ready_q      <= 1'b1;
            align_valid_q   <= 1'b0;
            align_pp_q      <= '0;
            align_exp_q     <= '0;
            align_exp_max_q <= EXP_MIN;
            align_shift_q   <= '0;
            align_idx_q     <= '0;
            align_last_q    <= 1'b0;
            group_done_q    <= 1'b0;
        end else begin
            group_done_q <= 1'b0;
            unique case (state_q)
                LOAD: begin
                    if (in_valid_i) begin
                        pp_q[wr_cnt_q]  <= in_pp_i;
                        exp_q[wr_cnt_q] <= in_exp_i;
                        exp_max_q       <= exp_max_d;
                        if (wr_cnt_q == LAST) begin
                            state_q         <= ISSUE;
                            wr_cnt_q        <= '0;
                            rd_cnt_q        <= '0;
                            in_ready_q      <= 1'b0;
                            align_valid_q   <= 1'b1;
                            align_pp_q      <= pp_q[0];
                            align_exp_q     <= exp_q[0];
                            align_exp_max_q <= exp_max_d;
                            align_shift_q   <= sat_shift(exp_max_d, exp_q[0]);
                            align_idx_q     <= '0;
                            align_last_q    <= 1'b0;
                        end else begin
                            wr_cnt_q <= wr_cnt_q + 4'd1;
                        end
                    end
                end
                ISSUE: begin
                    if (align_ready_i) begin
                        if (align_last_q) begin
                            state_q         <= LOAD;
                            rd_cnt_q        <= '0;
                            exp_max_q       <= EXP_MIN;
                            in_ready_q      <= 1'b1;
                            align_valid_q   <= 1'b0;
                            align_exp_max_q <= EXP_MIN;
                            align_last_q    <= 1'b0;
                            group_done_q    <= 1'b1;
                        end else begin
                            rd_cnt_q      <= rd_nxt;
                            align_pp_q    <= pp_q[rd_nxt];
                            align_exp_q   <= exp_q[rd_nxt];
                            align_shift_q <= sat_shift(exp_max_q, exp_q[rd_nxt]);
                            align_idx_q   <= rd_nxt;
                            align_last_q  <= (rd_nxt == LAST);
                        end
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign in_ready_o      = in_ready_q;
    assign align_valid_o   = align_valid_q;
    assign align_pp_o      = align_pp_q;
    assign align_exp_o     = align_exp_q;
    assign align_exp_max_o = align_exp_max_q;
    assign align_shift_o   = align_shift_q;
    assign align_idx_o     = align_idx_q;
    assign align_last_o    = align_last_q;
    assign group_done_o    = group_done_q;

endmodule

// File: tb/tb_sd4_align_sched.sv
// Bench for sd4_align_sched: directed group table plus random groups
// against a group-level model, with stalls, gaps and mid-operation resets.
module tb_sd4_align_sched;

    localparam int N = 9;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [4:0] in_exp = '0;
    logic [4:0] in_pp = '0;
    logic       align_valid;
    logic       align_ready = 1'b0;
    logic [4:0] align_pp;
    logic [4:0] align_exp;
    logic [4:0] align_exp_max;
    logic [3:0] align_shift;
    logic [3:0] align_idx;
    logic       align_last;
    logic       group_done;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [N-1:0][4:0] ex;
        logic [N-1:0][4:0] pp;
        logic [4:0]        mx;
        logic [N-1:0][3:0] sh;
    } grp_t;
    typedef int ia_t [N];

    grp_t vec [4];

    sd4_align_sched #(.N(N), .EW(5), .PW(5)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .in_exp_i       (in_exp),
        .in_pp_i        (in_pp),
        .align_valid_o  (align_valid),
        .align_ready_i  (align_ready),
        .align_pp_o     (align_pp),
        .align_exp_o    (align_exp),
        .align_exp_max_o(align_exp_max),
        .align_shift_o  (align_shift),
        .align_idx_o    (align_idx),
        .align_last_o   (align_last),
        .group_done_o   (group_done)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, int act, int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d at %0t", nm, act, req, $time);
        end
    endtask

    function automatic grp_t mk(ia_t e, ia_t p, int m, ia_t s);
        grp_t g;
        for (int i = 0; i < N; i++) begin
            g.ex[i] = 5'(e[i]);
            g.pp[i] = 5'(p[i]);
            g.sh[i] = 4'(s[i]);
        end
        g.mx = 5'(m);
        return g;
    endfunction

    // Group max over nonzero magnitudes, then clamped differences.
    function automatic grp_t model(grp_t g);
        int mx;
        int e;
        int d;
        mx = -16;
        for (int i = 0; i < N; i++) begin
            e = $signed(g.ex[i]);
            if (g.pp[i][3:0] != 0 && e > mx) mx = e;
        end
        g.mx = 5'(mx);
        for (int i = 0; i < N; i++) begin
            e = $signed(g.ex[i]);
            d = mx - e;
            g.sh[i] = (d < 0 || d > 15) ? 4'd15 : 4'(d);
        end
        return g;
    endfunction

    function automatic grp_t rnd_grp();
        grp_t g;
        g = '0;
        for (int i = 0; i < N; i++) begin
            g.ex[i] = 5'($urandom_range(31));
            g.pp[i] = 5'($urandom_range(31));
            if ($urandom_range(3) == 0) g.pp[i][3:0] = 4'd0;
        end
        return model(g);
    endfunction

    task automatic chk_reset(string t);
        chk({t, "_in_ready"}, in_ready, 1);
        chk({t, "_valid"}, align_valid, 0);
        chk({t, "_pp"}, align_pp, 0);
        chk({t, "_exp"}, align_exp, 0);
        chk({t, "_exp_max"}, align_exp_max, 16);
        chk({t, "_shift"}, align_shift, 0);
        chk({t, "_idx"}, align_idx, 0);
        chk({t, "_last"}, align_last, 0);
        chk({t, "_done"}, group_done, 0);
    endtask

    task automatic load_phase(grp_t g, int cnt, int gap, bit first_done);
        int acc = 0;
        int cyc = 0;
        while (acc < cnt) begin
            @(negedge clk);
            chk("group_done", group_done, (cyc == 0 && first_done) ? 1 : 0);
            chk("load_in_ready", in_ready, 1);
            chk("load_valid", align_valid, 0);
            if ($urandom_range(99) < gap) begin
                in_valid = 1'b0;
                in_exp   = 5'($urandom);
                in_pp    = 5'($urandom);
            end else begin
                in_valid = 1'b1;
                in_exp   = g.ex[acc];
                in_pp    = g.pp[acc];
                acc++;
            end
            cyc++;
            if (cyc > 1000) begin
                chk("load_timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic issue_phase(grp_t g, int stall, int lim);
        int k = 0;
        int cyc = 0;
        while (k < lim) begin
            @(negedge clk);
            if (cyc == 0) chk("latency_valid", align_valid, 1);
            chk("iss_in_ready", in_ready, 0);
            chk("iss_valid", align_valid, 1);
            chk("iss_pp", align_pp, g.pp[k]);
            chk("iss_exp", align_exp, g.ex[k]);
            chk("iss_exp_max", align_exp_max, g.mx);
            chk("iss_shift", align_shift, g.sh[k]);
            chk("iss_idx", align_idx, k);
            chk("iss_last", align_last, (k == N-1) ? 1 : 0);
            align_ready = ($urandom_range(99) >= stall);
            in_valid    = 1'($urandom_range(1));
            in_exp      = 5'($urandom);
            in_pp       = 5'($urandom);
            if (align_ready) k++;
            cyc++;
            if (cyc > 1000) begin
                chk("issue_timeout", 0, 1);
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ia_t  e, p, s;
        grp_t g;

        e = '{0, 1, 2, 3, 4, 5, 6, 7, -3};
        p = '{3, 3, 3, 3, 3, 3, 3, 3, 3};
        s = '{7, 6, 5, 4, 3, 2, 1, 0, 10};
        vec[0] = mk(e, p, 7, s);
        e = '{15, -16, 0, 1, 2, 3, 4, 5, 6};
        s = '{0, 15, 15, 14, 13, 12, 11, 10, 9};
        vec[1] = mk(e, p, 15, s);
        e = '{12, 3, 2, 1, 0, -1, -2, 3, -8};
        p = '{16, 1, 18, 7, 31, 8, 21, 6, 25};
        s = '{15, 0, 1, 2, 3, 4, 5, 0, 11};
        vec[2] = mk(e, p, 3, s);
        e = '{5, -3, 0, 15, -16, 7, 2, -1, 9};
        p = '{0, 16, 0, 16, 0, 0, 16, 0, 16};
        s = '{15, 15, 15, 15, 0, 15, 15, 15, 15};
        vec[3] = mk(e, p, -16, s);

        repeat (2) @(negedge clk);
        chk_reset("por");
        rst_n = 1'b1;

        for (int v = 0; v < 4; v++) begin
            load_phase(vec[v], N, 0, v > 0);
            issue_phase(vec[v], 0, N);
        end
        for (int v = 0; v < 4; v++) begin
            load_phase(vec[v], N, 30, 1'b1);
            issue_phase(vec[v], 40, N);
        end
        for (int r = 0; r < 20; r++) begin
            g = rnd_grp();
            load_phase(g, N, (r % 2 == 1) ? 35 : 0, 1'b1);
            issue_phase(g, (r % 3 == 0) ? 0 : 45, N);
        end

        g = rnd_grp();
        load_phase(g, 4, 20, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset("rst_load");
        @(negedge clk);
        rst_n = 1'b1;

        g = rnd_grp();
        load_phase(g, N, 0, 1'b0);
        issue_phase(g, 0, 5);
        @(negedge clk);
        align_ready = 1'b0;
        in_valid    = 1'b0;
        chk("mid_idx", align_idx, 5);
        #2 rst_n = 1'b0;
        #1 chk_reset("rst_issue");
        @(negedge clk);
        rst_n = 1'b1;

        g = rnd_grp();
        load_phase(g, N, 10, 1'b0);
        issue_phase(g, 20, N);
        @(negedge clk);
        in_valid = 1'b0;
        chk("final_done", group_done, 1);
        chk("final_in_ready", in_ready, 1);
        chk("final_valid", align_valid, 0);
        @(negedge clk);
        chk("final_done_pulse", group_done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
